// File: rtl/debug_pkg.sv
// Shared opcodes, ACK codes, dump source selectors/lengths and the sequencer
// state/mode types for the UART debug sequencer.
package debug_pkg;

  localparam logic [7:0] CMD_DUMP_REGS  = 8'h01;
  localparam logic [7:0] CMD_DUMP_IFID  = 8'h02;
  localparam logic [7:0] CMD_DUMP_IDEX  = 8'h03;
  localparam logic [7:0] CMD_DUMP_EXMEM = 8'h04;
  localparam logic [7:0] CMD_DUMP_MEMWB = 8'h05;
  localparam logic [7:0] CMD_LOAD       = 8'h07;
  localparam logic [7:0] CMD_MODE_CONT  = 8'h08;
  localparam logic [7:0] CMD_MODE_STEP  = 8'h11;
  localparam logic [7:0] CMD_RUN        = 8'h0D;
  localparam logic [7:0] CMD_STEP       = 8'h0A;
  localparam logic [7:0] CMD_STOP       = 8'h0B;

  localparam logic [7:0] ACK_OK  = 8'h52;
  localparam logic [7:0] ACK_ERR = 8'h45;

  localparam logic [2:0] SEL_REGS  = 3'd1;
  localparam logic [2:0] SEL_IFID  = 3'd2;
  localparam logic [2:0] SEL_IDEX  = 3'd3;
  localparam logic [2:0] SEL_EXMEM = 3'd4;
  localparam logic [2:0] SEL_MEMWB = 3'd5;

  localparam logic [7:0] LEN_REGS  = 8'd128;
  localparam logic [7:0] LEN_IFID  = 8'd8;
  localparam logic [7:0] LEN_IDEX  = 8'd17;
  localparam logic [7:0] LEN_EXMEM = 8'd10;
  localparam logic [7:0] LEN_MEMWB = 8'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_BYTE,
    ST_LOAD_WR,
    ST_DUMP_TX,
    ST_DUMP_WAIT,
    ST_ACK_TX,
    ST_ACK_WAIT
  } state_e;

  typedef enum logic {
    MODE_CONT,
    MODE_STEP
  } mode_e;

  function automatic logic [7:0] dump_len(input logic [2:0] sel);
    case (sel)
      SEL_REGS:  dump_len = LEN_REGS;
      SEL_IFID:  dump_len = LEN_IFID;
      SEL_IDEX:  dump_len = LEN_IDEX;
      SEL_EXMEM: dump_len = LEN_EXMEM;
      SEL_MEMWB: dump_len = LEN_MEMWB;
      default:   dump_len = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/dump_serializer.sv
// Walks the byte index of one dump source and runs the single-outstanding
// transmit handshake for each byte.
module dump_serializer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] sel_i,
  input  logic       send_i,
  input  logic       tx_done_i,
  input  logic [7:0] dump_byte_i,
  output logic [2:0] dump_sel_o,
  output logic [7:0] dump_idx_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       next_o,
  output logic       done_o
);
  import debug_pkg::*;

  logic [2:0] sel_q, sel_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       pend_q, pend_d;
  logic       start_q, start_d;
  logic       advance;
  logic       last;

  assign advance = pend_q & tx_done_i;
  assign last    = (idx_q == (len_q - 8'd1));

  // A send request is ignored while a byte is still outstanding.
  always_comb begin
    sel_d   = sel_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    pend_d  = pend_q;
    start_d = 1'b0;
    if (start_i) begin
      sel_d  = sel_i;
      len_d  = dump_len(sel_i);
      idx_d  = '0;
      pend_d = 1'b0;
    end else begin
      if (send_i && !pend_q) begin
        start_d = 1'b1;
        data_d  = dump_byte_i;
        pend_d  = 1'b1;
      end
      if (advance) begin
        pend_d = 1'b0;
        idx_d  = idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      start_q <= start_d;
    end
  end

  assign dump_sel_o = sel_q;
  assign dump_idx_o = idx_q;
  assign tx_start_o = start_q;
  assign tx_data_o  = data_q;
  assign next_o     = advance & ~last;
  assign done_o     = advance & last;

endmodule

// File: rtl/debug_sequencer.sv
// UART-driven debug command sequencer: program load, pipeline run/step
// control and pipeline-state dumps, each answered by a one-byte ACK.
module debug_sequencer #(
  parameter int ADDR_WIDTH      = 6,
  parameter int MAX_INSTRUCTION = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  output logic                  o_cpu_rst,
  output logic                  o_cpu_en,
  output logic [2:0]            o_dump_sel,
  output logic [7:0]            o_dump_idx,
  input  logic [7:0]            i_dump_byte
);
  import debug_pkg::*;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic        run_q, run_d;
  logic        step_q, step_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        ack_start_q, ack_start_d;
  logic        ack_owner_q, ack_owner_d;
  logic [7:0]  ack_data_q, ack_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d;

  logic        ser_start, ser_send, ser_next, ser_done, ser_tx_start;
  logic [7:0]  ser_tx_data;

  dump_serializer u_dump_serializer (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .start_i     (ser_start),
    .sel_i       (i_rx_data[2:0]),
    .send_i      (ser_send),
    .tx_done_i   (i_tx_done),
    .dump_byte_i (i_dump_byte),
    .dump_sel_o  (o_dump_sel),
    .dump_idx_o  (o_dump_idx),
    .tx_start_o  (ser_tx_start),
    .tx_data_o   (ser_tx_data),
    .next_o      (ser_next),
    .done_o      (ser_done)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    run_d       = run_q;
    step_d      = 1'b0;
    ack_start_d = 1'b0;
    ack_owner_d = ack_owner_q;
    ack_data_d  = ack_data_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    ser_start   = 1'b0;
    ser_send    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          ack_data_d = ACK_OK;
          state_d    = ST_ACK_TX;
          case (i_rx_data)
            CMD_DUMP_REGS, CMD_DUMP_IFID, CMD_DUMP_IDEX,
            CMD_DUMP_EXMEM, CMD_DUMP_MEMWB: begin
              if (run_q && (mode_q == MODE_CONT)) begin
                ack_data_d = ACK_ERR;
              end else begin
                ser_start   = 1'b1;
                ack_owner_d = 1'b0;
                state_d     = ST_DUMP_TX;
              end
            end
            CMD_LOAD: begin
              run_d   = 1'b0;
              state_d = ST_LOAD_CNT;
            end
            CMD_MODE_CONT: begin
              mode_d = MODE_CONT;
              run_d  = 1'b0;
            end
            CMD_MODE_STEP: begin
              mode_d = MODE_STEP;
              run_d  = 1'b0;
            end
            CMD_RUN:  run_d = 1'b1;
            CMD_STEP: begin
              if (run_q && (mode_q == MODE_STEP)) step_d = 1'b1;
              else ack_data_d = ACK_ERR;
            end
            CMD_STOP: run_d = 1'b0;
            default:  ack_data_d = ACK_ERR;
          endcase
        end
      end
      ST_LOAD_CNT: begin
        if (i_rx_valid) begin
          if ((i_rx_data == 8'd0) || (int'(i_rx_data) > MAX_INSTRUCTION)) begin
            ack_data_d = ACK_ERR;
            state_d    = ST_ACK_TX;
          end else begin
            cnt_d   = i_rx_data;
            widx_d  = '0;
            bidx_d  = '0;
            state_d = ST_LOAD_BYTE;
          end
        end
      end
      ST_LOAD_BYTE: begin
        // Shifting in from the top leaves the first byte received in [7:0].
        if (i_rx_valid) begin
          word_d = {i_rx_data, word_q[31:8]};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) state_d = ST_LOAD_WR;
        end
      end
      ST_LOAD_WR: begin
        if (widx_q == (cnt_q - 8'd1)) begin
          ack_data_d = ACK_OK;
          state_d    = ST_ACK_TX;
        end else begin
          widx_d  = widx_q + 8'd1;
          state_d = ST_LOAD_BYTE;
        end
      end
      ST_DUMP_TX: begin
        ser_send = 1'b1;
        state_d  = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (ser_done) begin
          ack_data_d = ACK_OK;
          state_d    = ST_ACK_TX;
        end else if (ser_next) begin
          state_d = ST_DUMP_TX;
        end
      end
      ST_ACK_TX: begin
        ack_start_d = 1'b1;
        ack_owner_d = 1'b1;
        state_d     = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (i_tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cpu_rst_d = (state_d == ST_LOAD_CNT) || (state_d == ST_LOAD_BYTE) ||
                (state_d == ST_LOAD_WR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_CONT;
      run_q       <= 1'b0;
      step_q      <= 1'b0;
      cpu_rst_q   <= 1'b1;
      ack_start_q <= 1'b0;
      ack_owner_q <= 1'b0;
      ack_data_q  <= '0;
      cnt_q       <= '0;
      widx_q      <= '0;
      bidx_q      <= '0;
      word_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      run_q       <= run_d;
      step_q      <= step_d;
      cpu_rst_q   <= cpu_rst_d;
      ack_start_q <= ack_start_d;
      ack_owner_q <= ack_owner_d;
      ack_data_q  <= ack_data_d;
      cnt_q       <= cnt_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
    end
  end

  assign o_tx_start   = ser_tx_start | ack_start_q;
  assign o_tx_data    = ack_owner_q ? ack_data_q : ser_tx_data;
  assign o_imem_we    = (state_q == ST_LOAD_WR);
  assign o_imem_addr  = ADDR_WIDTH'(widx_q);
  assign o_imem_wdata = word_q;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_cpu_en     = step_q | (run_q & (mode_q == MODE_CONT));

endmodule

// File: tb/tb_debug_sequencer.sv
// Scoreboard bench for debug_sequencer: expected tx bytes and imem writes are
// queued as commands are driven and checked as the DUT produces them.
module tb_debug_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        cpu_en;
  logic [2:0]  dump_sel;
  logic [7:0]  dump_idx;
  logic [7:0]  dump_byte;

  always #5 clk = ~clk;

  assign dump_byte = dump_idx + 8'h10;

  debug_sequencer #(.ADDR_WIDTH(6), .MAX_INSTRUCTION(64)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .o_imem_we    (imem_we),
    .o_imem_addr  (imem_addr),
    .o_imem_wdata (imem_wdata),
    .o_cpu_rst    (cpu_rst),
    .o_cpu_en     (cpu_en),
    .o_dump_sel   (dump_sel),
    .o_dump_idx   (dump_idx),
    .i_dump_byte  (dump_byte)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    bit         chk_sel;
  } tx_exp_t;

  tx_exp_t      exp_tx[$];
  logic [37:0]  exp_we[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int tx_cnt    = 0;
  int tx_starts = 0;
  int en_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b, input logic [2:0] s, input bit c);
    tx_exp_t e;
    e.data = b;
    e.sel = s;
    e.chk_sel = c;
    exp_tx.push_back(e);
  endtask

  task automatic push_we(input logic [5:0] a, input logic [31:0] d);
    exp_we.push_back({a, d});
  endtask

  // Transmitter model (done 3 cycles after start) plus output monitor.
  always @(negedge clk) begin
    bit busy;
    tx_exp_t e;
    logic [37:0] w;
    busy = (tx_cnt != 0);
    tx_done = 1'b0;
    if (rst) begin
      tx_cnt = 0;
    end else begin
      if (tx_cnt != 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (tx_start) begin
        tx_starts++;
        chk("tx_one_outstanding", 32'(busy), 32'd0);
        chk("tx_expected_pending", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.data));
          if (e.chk_sel) chk("dump_sel", 32'(dump_sel), 32'(e.sel));
        end
        tx_cnt = 3;
      end
      if (imem_we) begin
        chk("we_expected_pending", 32'(exp_we.size() != 0), 32'd1);
        if (exp_we.size() != 0) begin
          w = exp_we.pop_front();
          chk("imem_addr", 32'(imem_addr), 32'(w[37:32]));
          chk("imem_wdata", imem_wdata, w[31:0]);
        end
      end
      if (cpu_en) en_cycles++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_we.size() == 0 && tx_cnt == 0 && !tx_done) break;
    end
    chk({tag, "_in_time"}, 32'(i < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_dump_sel"}, 32'(dump_sel), 32'd0);
    chk({tag, "_dump_idx"}, 32'(dump_idx), 32'd0);
  endtask

  initial begin
    logic [7:0] prog [8];
    int base;
    prog = '{8'h01, 8'h00, 8'h01, 8'h3C, 8'h03, 8'h00, 8'h03, 8'h3C};

    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("cpu_rst_release", 32'(cpu_rst), 32'd0);

    // Two-word load
    push_we(6'd0, 32'h3C010001);
    push_we(6'd1, 32'h3C030003);
    push_tx(8'h52, 3'd0, 1'b0);
    send(8'h07);
    chk("load_cpu_rst_high", 32'(cpu_rst), 32'd1);
    send(8'h02);
    foreach (prog[i]) send(prog[i]);
    wait_idle("load2");
    chk("load_cpu_rst_low", 32'(cpu_rst), 32'd0);

    // Single-word load
    push_we(6'd0, 32'hDEADBEEF);
    push_tx(8'h52, 3'd0, 1'b0);
    send(8'h07); send(8'h01);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    wait_idle("load1");

    // Illegal counts
    push_tx(8'h45, 3'd0, 1'b0);
    send(8'h07); send(8'h00);
    wait_idle("load_zero");
    chk("bad_cnt_cpu_rst", 32'(cpu_rst), 32'd0);
    push_tx(8'h45, 3'd0, 1'b0);
    send(8'h07); send(8'd65);
    wait_idle("load_65");

    // Step mode
    push_tx(8'h52, 3'd0, 1'b0); send(8'h11); wait_idle("mode_step");
    push_tx(8'h52, 3'd0, 1'b0); send(8'h0D); wait_idle("run_step");
    chk("step_run_en_low", 32'(cpu_en), 32'd0);
    en_cycles = 0;
    push_tx(8'h52, 3'd0, 1'b0); send(8'h0A); wait_idle("step");
    chk("step_en_cycles", 32'(en_cycles), 32'd1);
    push_tx(8'h52, 3'd0, 1'b0); send(8'h0B); wait_idle("stop");
    push_tx(8'h45, 3'd0, 1'b0); send(8'h0A); wait_idle("step_stopped");

    // Dumps
    for (int i = 0; i < 10; i++) push_tx(8'(i + 16), 3'd4, 1'b1);
    push_tx(8'h52, 3'd0, 1'b0);
    send(8'h04);
    wait_idle("dump_exmem");
    for (int i = 0; i < 128; i++) push_tx(8'(i + 16), 3'd1, 1'b1);
    push_tx(8'h52, 3'd0, 1'b0);
    send(8'h01);
    wait_idle("dump_regs");
    for (int i = 0; i < 8; i++) push_tx(8'(i + 16), 3'd2, 1'b1);
    push_tx(8'h52, 3'd0, 1'b0);
    send(8'h02);
    wait_idle("dump_ifid");

    // Bytes arriving mid-dump (some alongside tx_done) are dropped
    for (int i = 0; i < 9; i++) push_tx(8'(i + 16), 3'd5, 1'b1);
    push_tx(8'h52, 3'd0, 1'b0);
    send(8'h05);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_data = 8'h0D;
      rx_valid = ~rx_valid;
    end
    rx_valid = 1'b0;
    wait_idle("dump_junk");
    push_tx(8'h45, 3'd0, 1'b0); send(8'h0A); wait_idle("junk_not_run");

    // Continuous mode
    push_tx(8'h52, 3'd0, 1'b0); send(8'h08); wait_idle("mode_cont");
    push_tx(8'h52, 3'd0, 1'b0); send(8'h0D); wait_idle("run_cont");
    chk("cont_en_high", 32'(cpu_en), 32'd1);
    repeat (5) @(negedge clk);
    chk("cont_en_held", 32'(cpu_en), 32'd1);
    push_tx(8'h45, 3'd0, 1'b0); send(8'h03); wait_idle("dump_running");
    chk("cont_en_after_err", 32'(cpu_en), 32'd1);
    push_tx(8'h45, 3'd0, 1'b0); send(8'h55); wait_idle("unknown_cmd");
    push_tx(8'h52, 3'd0, 1'b0);
    @(negedge clk);
    rx_data = 8'h0B;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("stop_en_next_cycle", 32'(cpu_en), 32'd0);
    wait_idle("stop_cont");

    // Reset in the middle of an ID/EX dump
    base = tx_starts;
    for (int i = 0; i < 3; i++) push_tx(8'(i + 16), 3'd3, 1'b1);
    send(8'h03);
    for (int i = 0; i < 500; i++) begin
      if (tx_starts - base >= 3) break;
      @(negedge clk);
    end
    chk("middump_three_bytes", 32'(tx_starts - base), 32'd3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("middump");
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("middump_tx_left", 32'(exp_tx.size()), 32'd0);
    chk("middump_no_extra_tx", 32'(tx_starts - base), 32'd3);
    chk("we_queue_empty", 32'(exp_we.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
